division_issue_queue: RTL

Upstream feeder for the 8-bit non-pipelined divider. Accepts dividend/divisor pairs over a ready/valid stream, buffers them in a small FIFO, and issues them one at a time to the divider with a single-cycle start pulse. It waits for the divider's one-cycle result strobe, then presents quotient and remainder on a ready/valid output with error flags. Exactly one operation is in flight at any time.

---
 rtl/division_pkg.sv | 18 +
 rtl/division_op_fifo.sv | 56 +++++
 rtl/division_issue_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/division_pkg.sv
// Shared types and constants for the divider issue queue.
// Operand words are packed {dividend, divisor}; results are {quotient, remainder}.
package division_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } div_state_e;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned OP_W  = 2 * DIV_W;

    localparam logic [DIV_W-1:0] DIV_ERR_CODE = 8'hFF;

    localparam int unsigned QUOT_MSB = 15;
    localparam int unsigned REM_MSB  = 7;

endpackage

// File: rtl/division_op_fifo.sv
// Operand FIFO: DEPTH x WIDTH storage with count-based full/empty.
// Pushes while full and pops while empty are ignored.
module division_op_fifo
    import division_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = OP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_en, pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_en) wptr_q <= wptr_q + PtrW'(1);
            if (pop_en)  rptr_q <= rptr_q + PtrW'(1);
            if (push_en && !pop_en) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_en && pop_en) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/division_issue_queue.sv
// Feeds the non-pipelined 8-bit divider from an operand FIFO, one op in flight,
// with a timeout watchdog and a ready/valid result register.
module division_issue_queue
    import division_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] in_a,
    input  logic [DIV_W-1:0] in_b,
    output logic             div_rst,
    output logic             div_start,
    output logic [DIV_W-1:0] div_a,
    output logic [DIV_W-1:0] div_b,
    input  logic             div_valid,
    input  logic [OP_W-1:0]  div_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] out_quot,
    output logic [DIV_W-1:0] out_rem,
    output logic             out_err_dz,
    output logic             out_err_to,
    output logic             busy
);

    localparam int unsigned TimerW = $clog2(TIMEOUT);

    div_state_e       state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic             dz_q, dz_d;
    logic             div_start_q, div_start_d;
    logic [DIV_W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic             out_valid_q, out_valid_d;
    logic [DIV_W-1:0] out_quot_q, out_quot_d, out_rem_q, out_rem_d;
    logic             err_dz_q, err_dz_d, err_to_q, err_to_d;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [OP_W-1:0]  fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;

    division_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        dz_d        = dz_q;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        out_valid_d = out_valid_q;
        out_quot_d  = out_quot_q;
        out_rem_d   = out_rem_q;
        err_dz_d    = err_dz_q;
        err_to_d    = err_to_q;
        fifo_pop    = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A held result blocks issue, so backpressure accumulates in the FIFO.
                if (!fifo_empty && !out_valid_q) begin
                    fifo_pop    = 1'b1;
                    div_a_d     = fifo_rdata[QUOT_MSB -: DIV_W];
                    div_b_d     = fifo_rdata[REM_MSB -: DIV_W];
                    dz_d        = (fifo_rdata[REM_MSB -: DIV_W] == '0);
                    div_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + TimerW'(1);
                if (div_valid) begin
                    out_quot_d  = div_p[QUOT_MSB -: DIV_W];
                    out_rem_d   = div_p[REM_MSB -: DIV_W];
                    err_dz_d    = dz_q;
                    err_to_d    = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                    out_quot_d  = DIV_ERR_CODE;
                    out_rem_d   = DIV_ERR_CODE;
                    err_dz_d    = dz_q;
                    err_to_d    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            dz_q        <= 1'b0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_quot_q  <= '0;
            out_rem_q   <= '0;
            err_dz_q    <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dz_q        <= dz_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            out_valid_q <= out_valid_d;
            out_quot_q  <= out_quot_d;
            out_rem_q   <= out_rem_d;
            err_dz_q    <= err_dz_d;
            err_to_q    <= err_to_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign div_rst    = !reset;
    assign div_start  = div_start_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign out_valid  = out_valid_q;
    assign out_quot   = out_quot_q;
    assign out_rem    = out_rem_q;
    assign out_err_dz = err_dz_q;
    assign out_err_to = err_to_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule
